// File: rtl/or_in_skid_buffer.sv
// or_in_skid_buffer: 2-entry skid buffer feeding the OR reduction from flops,
// with in_ready registered so it never depends combinationally on out_ready.
module or_in_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    assign out_valid = state_q != EMPTY;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                main_d  = in_fire ? in_data : main_q;
                state_d = in_fire ? BUSY : EMPTY;
            end
            BUSY: begin
                main_d  = (in_fire & out_fire) ? in_data : main_q;
                skid_d  = (in_fire & !out_fire) ? in_data : skid_q;
                state_d = (in_fire & !out_fire) ? FULL : (!in_fire & out_fire) ? EMPTY : BUSY;
            end
            FULL: begin
                main_d  = out_fire ? skid_q : main_q;
                state_d = out_fire ? BUSY : FULL;
            end
            default: state_d = EMPTY;
        endcase
        // in_ready is precomputed from next state so it leaves a flop directly
        in_ready_d = state_d != FULL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_or_in_skid_buffer.sv
// tb_or_in_skid_buffer: directed and random checks of the OR-stage skid buffer
// against a FIFO scoreboard model.
module tb_or_in_skid_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [1:0]  occupancy;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] q[$];

    or_in_skid_buffer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic in_f, out_f, stalled;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", 32'(out_data), 0);
        rst = 1'b0;
        tick();

        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h8001;
        tick();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'h8001);
        check("single_occ1", 32'(occupancy), 1);
        tick();
        check("single_occ0", 32'(occupancy), 0);
        check("single_valid0", 32'(out_valid), 0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
        tick();
        check("bp_occ1", 32'(occupancy), 1);
        check("bp_ready1", 32'(in_ready), 1);
        in_data = 16'h0002;
        tick();
        in_valid = 1'b0;
        check("bp_occ2", 32'(occupancy), 2);
        check("bp_ready0", 32'(in_ready), 0);
        check("bp_data", 32'(out_data), 32'h0001);
        in_valid = 1'b1; in_data = 16'hdead;
        tick();
        in_valid = 1'b0;
        check("bp_hold_data", 32'(out_data), 32'h0001);
        check("bp_hold_occ", 32'(occupancy), 2);

        out_ready = 1'b1;
        tick();
        check("drain_data2", 32'(out_data), 32'h0002);
        check("drain_occ1", 32'(occupancy), 1);
        tick();
        check("drain_occ0", 32'(occupancy), 0);
        check("drain_ready", 32'(in_ready), 1);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00aa;
        tick();
        in_data = 16'h00bb;
        tick();
        in_valid = 1'b0;
        check("pre_rst_occ", 32'(occupancy), 2);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_occ", 32'(occupancy), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_out_data", 32'(out_data), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 1);
        check("post_rst_valid", 32'(out_valid), 0);

        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 16'(i);
            tick();
            check("stream_valid", 32'(out_valid), 1);
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_occ", 32'(occupancy), 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_occ", 32'(occupancy), 0);

        stalled = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_occ", 32'(occupancy), 32'(q.size()));
            check("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            check("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("rnd_data", 32'(out_data), 32'(q[0]));
                check("rnd_or", 32'(|out_data), 32'(q[0] != 16'h0));
            end
            if (!stalled) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_data  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            end
            out_ready = $urandom_range(0, 2) != 0;
            in_f    = in_valid & (q.size() < 2);
            out_f   = out_ready & (q.size() > 0);
            stalled = in_valid & !in_f;
            tick();
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back(in_data);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        check("final_occ", 32'(occupancy), 0);
        check("final_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
